m_wishbonereg_bank: RTL

Parametrised successor to the single midgetv wishbone register. It provides `NREG` 32-bit read/write registers on a Wishbone classic slave port, with byte-lane writes and 0..7 programmable wait states. Each register exposes its contents and a per-register write pulse to the surrounding logic. It sits next to `m_midgetv_core` in simulation and FPGA tops. The top's address decode drives `STB_I` and `ADR_I`.

---
 rtl/p_wbregbank.sv | 16 +
 rtl/m_wbregbank_ackgen.sv | 72 +++++++
 rtl/m_wishbonereg_bank.sv | 71 +++++++
 3 files changed

// File: rtl/p_wbregbank.sv
// Shared definitions for the Wishbone register bank: FSM encoding, counter width
// and legal parameter ranges.
package p_wbregbank;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10
  } state_t;

  localparam int unsigned WSW      = 3;
  localparam int unsigned NREG_MIN = 2;
  localparam int unsigned NREG_MAX = 16;
  localparam int unsigned WS_MAX   = 7;

endpackage

// File: rtl/m_wbregbank_ackgen.sv
// Access sequencer: IDLE/WAIT/ACK FSM with wait-state counter, registered ACK and
// a commit strobe that is high in the cycle whose closing edge enters ACK.
module m_wbregbank_ackgen
  import p_wbregbank::*;
#(
  parameter int unsigned WAITSTATES = 0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_stb,
  output logic o_ack,
  output logic o_commit_c
);

  localparam logic [WSW-1:0] CNT_LOAD = (WAITSTATES == 0) ? WSW'(0) : WSW'(WAITSTATES - 1);

  if (WAITSTATES > WS_MAX) begin : g_bad_ws
    $error("m_wbregbank_ackgen: WAITSTATES out of range 0..7");
  end

  state_t         r_state, w_state_nxt;
  logic [WSW-1:0] r_cnt, w_cnt_nxt;
  logic           r_ack;

  // Next-state and commit decode; abort in WAIT takes priority over expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_commit_c  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_stb) begin
          if (WAITSTATES == 0) begin
            w_state_nxt = ST_ACK;
            o_commit_c  = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!i_stb) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = WSW'(0);
        end else if (r_cnt == WSW'(0)) begin
          w_state_nxt = ST_ACK;
          o_commit_c  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - WSW'(1);
        end
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= WSW'(0);
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= (w_state_nxt == ST_ACK);
    end
  end

  assign o_ack = r_ack;

endmodule

// File: rtl/m_wishbonereg_bank.sv
// NREG x 32-bit Wishbone classic register bank with byte-lane writes, programmable
// wait states, flattened register outputs and per-register write pulses.
module m_wishbonereg_bank
  import p_wbregbank::*;
#(
  parameter int unsigned NREG       = 4,
  parameter int unsigned WAITSTATES = 0,
  parameter logic [31:0] RESETVAL   = 32'h0
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [3:0]              SEL_I,
  input  logic [$clog2(NREG)-1:0] ADR_I,
  input  logic [31:0]             DAT_I,
  output logic                    ACK_O,
  output logic [31:0]             DAT_O,
  output logic [32*NREG-1:0]      regs_o,
  output logic [NREG-1:0]         wrpulse_o
);

  if (NREG < NREG_MIN || NREG > NREG_MAX || (NREG & (NREG - 1)) != 0) begin : g_bad_nreg
    $error("m_wishbonereg_bank: NREG must be a power of two in 2..16");
  end

  logic [31:0]     r_regs [NREG];
  logic [31:0]     r_dat;
  logic [NREG-1:0] r_wrpulse;
  logic            w_commit;

  m_wbregbank_ackgen #(
    .WAITSTATES(WAITSTATES)
  ) u_ackgen (
    .i_clk     (CLK_I),
    .i_rst     (RST_I),
    .i_stb     (STB_I),
    .o_ack     (ACK_O),
    .o_commit_c(w_commit)
  );

  // Commit happens on the edge entering ACK; DAT_O and pulses self-clear after one cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int k = 0; k < int'(NREG); k++) r_regs[k] <= RESETVAL;
      r_dat     <= 32'h0;
      r_wrpulse <= '0;
    end else begin
      r_dat     <= 32'h0;
      r_wrpulse <= '0;
      if (w_commit) begin
        if (WE_I) begin
          for (int b = 0; b < 4; b++) begin
            if (SEL_I[b]) r_regs[ADR_I][8*b +: 8] <= DAT_I[8*b +: 8];
          end
          r_wrpulse[ADR_I] <= 1'b1;
        end else begin
          r_dat <= r_regs[ADR_I];
        end
      end
    end
  end

  for (genvar k = 0; k < int'(NREG); k++) begin : g_flat
    assign regs_o[32*k +: 32] = r_regs[k];
  end

  assign DAT_O     = r_dat;
  assign wrpulse_o = r_wrpulse;

endmodule
